tl_sram_responder: RTL and testbench

// - TileLink-UL responder (slave) in front of a local 64-bit SRAM; the counterpart of the video/DMA GET initiators.
// - Serves Get bursts (AccessAckData) and PutFullData/PutPartialData (AccessAck); one transaction outstanding.
// - Sits on the system TileLink bus as the scratch/framebuffer memory for display and capture masters.

---
 rtl/tl_pkg.sv | 24 ++
 rtl/tl_resp_fifo2.sv | 47 ++++
 rtl/tl_sram_responder.sv | 180 ++++++++++++++++++
 tb/tb_tl_sram_responder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared TileLink-UL opcodes, responder FSM states and burst-length helper.
// Pure definitions: no logic, no latency, no flow control.
package tl_pkg;

   localparam logic [2:0] PUT_FULL        = 3'd0;
   localparam logic [2:0] PUT_PARTIAL     = 3'd1;
   localparam logic [2:0] GET             = 3'd4;
   localparam logic [2:0] ACCESS_ACK      = 3'd0;
   localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      ACK   = 2'd3
   } state_t;

   // Unsupported sizes (>6) are denied, so they collapse to a single beat.
   function automatic logic [3:0] beats_from_size(input logic [2:0] size);
      if (size <= 3'd3 || size > 3'd6) return 4'd1;
      return 4'd1 << (size - 3'd3);
   endfunction

endpackage

// File: rtl/tl_resp_fifo2.sv
// Two-entry valid/ready FIFO for D-channel read beats; push-to-pop latency 1 cycle.
// Refuses pushes when full; o_count exposes occupancy so the producer can pre-reserve space.
module tl_resp_fifo2 #(
   parameter int W = 65
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_push_vld,
   output logic         o_push_rdy,
   input  logic [W-1:0] i_push_dat,
   output logic         o_pop_vld,
   input  logic         i_pop_rdy,
   output logic [W-1:0] o_pop_dat,
   output logic [1:0]   o_count
);

   logic [W-1:0] r_mem [2];
   logic         r_wptr;
   logic         r_rptr;
   logic [1:0]   r_count;
   logic         w_push;
   logic         w_pop;

   assign o_push_rdy = (r_count != 2'd2);
   assign o_pop_vld  = (r_count != 2'd0);
   assign o_pop_dat  = r_mem[r_rptr];
   assign o_count    = r_count;
   assign w_push     = i_push_vld & o_push_rdy;
   assign w_pop      = o_pop_vld & i_pop_rdy;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_push_dat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (w_push) r_wptr <= ~r_wptr;
         if (w_pop)  r_rptr <= ~r_rptr;
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

endmodule

// File: rtl/tl_sram_responder.sv
// TileLink-UL responder over a local 64-bit SRAM, one transaction outstanding; Get data
// appears 2 cycles after the A handshake, then 1 beat/cycle while d_ready; D holds until accepted.
module tl_sram_responder
   import tl_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 32,
   parameter int MEM_WORDS     = 4096,
   parameter int SOURCE_WIDTH  = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     tl_bus_a_valid,
   output logic                     tl_bus_a_ready,
   input  logic [2:0]               tl_bus_a_payload_opcode,
   input  logic [2:0]               tl_bus_a_payload_param,
   input  logic [2:0]               tl_bus_a_payload_size,
   input  logic [SOURCE_WIDTH-1:0]  tl_bus_a_payload_source,
   input  logic [ADDRESS_WIDTH-1:0] tl_bus_a_payload_address,
   input  logic [7:0]               tl_bus_a_payload_mask,
   input  logic [63:0]              tl_bus_a_payload_data,
   output logic                     tl_bus_d_valid,
   input  logic                     tl_bus_d_ready,
   output logic [2:0]               tl_bus_d_payload_opcode,
   output logic [2:0]               tl_bus_d_payload_param,
   output logic [2:0]               tl_bus_d_payload_size,
   output logic [SOURCE_WIDTH-1:0]  tl_bus_d_payload_source,
   output logic                     tl_bus_d_payload_denied,
   output logic [63:0]              tl_bus_d_payload_data,
   output logic                     tl_bus_d_payload_corrupt
);

   localparam int IDX_W = $clog2(MEM_WORDS);

   state_t                  r_state;
   logic                    r_live;
   logic [2:0]              r_size;
   logic [SOURCE_WIDTH-1:0] r_source;
   logic [IDX_W-1:0]        r_base;
   logic [3:0]              r_beats;
   logic [3:0]              r_beat;
   logic [3:0]              r_dbeat;
   logic                    r_denied;
   logic                    r_rd_vld;
   logic [63:0]             r_rdata;
   logic [63:0]             r_mem [MEM_WORDS];

   logic             w_a_fire;
   logic             w_d_fire;
   logic             w_a_oor;
   logic             w_a_denied;
   logic             w_a_is_put;
   logic [3:0]       w_a_beats;
   logic [IDX_W-1:0] w_a_base;
   logic [IDX_W-1:0] w_beat_idx;
   logic [IDX_W-1:0] w_widx;
   logic             w_we;
   logic             w_rd_issue;
   logic [2:0]       w_occ;
   logic [1:0]       w_fifo_count;
   logic             w_fifo_vld;
   logic             w_fifo_pop_rdy;
   logic             w_fifo_push_rdy;
   logic [64:0]      w_fifo_push_dat;
   logic [64:0]      w_fifo_pop_dat;
   logic             w_unused;

   assign tl_bus_a_ready = r_live && (r_state == IDLE || r_state == WRITE);
   assign w_a_fire       = tl_bus_a_valid && tl_bus_a_ready;
   assign w_d_fire       = tl_bus_d_valid && tl_bus_d_ready;

   assign w_a_oor    = |tl_bus_a_payload_address[ADDRESS_WIDTH-1:IDX_W+3];
   assign w_a_denied = w_a_oor || (tl_bus_a_payload_size > 3'd6);
   assign w_a_is_put = (tl_bus_a_payload_opcode == PUT_FULL) ||
                       (tl_bus_a_payload_opcode == PUT_PARTIAL);
   assign w_a_beats  = beats_from_size(tl_bus_a_payload_size);
   assign w_a_base   = tl_bus_a_payload_address[IDX_W+2:3] & ~IDX_W'(w_a_beats - 4'd1);
   // Base is aligned to the burst, so OR-ing the beat number never leaves the block.
   assign w_beat_idx = r_base | IDX_W'(r_beat);
   assign w_widx     = (r_state == IDLE) ? w_a_base : w_beat_idx;
   assign w_we       = w_a_fire &&
                       ((r_state == IDLE && w_a_is_put && !w_a_denied) ||
                        (r_state == WRITE && !r_denied));

   // Occupancy counts the beat leaving this cycle so a streaming reader never bubbles.
   assign w_fifo_pop_rdy = tl_bus_d_ready && (r_state == READ);
   assign w_occ = {1'b0, w_fifo_count} + {2'b0, r_rd_vld} - {2'b0, w_fifo_vld & w_fifo_pop_rdy};
   assign w_rd_issue = (r_state == READ) && (r_beat < r_beats) && (w_occ < 3'd2);
   assign w_fifo_push_dat = {r_denied, r_denied ? 64'd0 : r_rdata};

   always_ff @(posedge clk) begin
      for (int b = 0; b < 8; b++) begin
         if (w_we && tl_bus_a_payload_mask[b])
            r_mem[w_widx][b*8 +: 8] <= tl_bus_a_payload_data[b*8 +: 8];
      end
      if (w_rd_issue) r_rdata <= r_mem[w_beat_idx];
   end

   tl_resp_fifo2 #(.W(65)) u_fifo (
      .clk        (clk),
      .rst_n      (reset_n),
      .i_push_vld (r_rd_vld),
      .o_push_rdy (w_fifo_push_rdy),
      .i_push_dat (w_fifo_push_dat),
      .o_pop_vld  (w_fifo_vld),
      .i_pop_rdy  (w_fifo_pop_rdy),
      .o_pop_dat  (w_fifo_pop_dat),
      .o_count    (w_fifo_count)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= IDLE;
         r_live   <= 1'b0;
         r_size   <= 3'd0;
         r_source <= '0;
         r_base   <= '0;
         r_beats  <= 4'd1;
         r_beat   <= 4'd0;
         r_dbeat  <= 4'd0;
         r_denied <= 1'b0;
         r_rd_vld <= 1'b0;
      end else begin
         r_live   <= 1'b1;
         r_rd_vld <= w_rd_issue;
         case (r_state)
            IDLE: begin
               if (w_a_fire) begin
                  r_size   <= tl_bus_a_payload_size;
                  r_source <= tl_bus_a_payload_source;
                  r_base   <= w_a_base;
                  r_beats  <= w_a_beats;
                  r_dbeat  <= 4'd0;
                  if (tl_bus_a_payload_opcode == GET) begin
                     r_denied <= w_a_denied;
                     r_beat   <= 4'd0;
                     r_state  <= READ;
                  end else if (w_a_is_put) begin
                     r_denied <= w_a_denied;
                     r_beat   <= 4'd1;
                     r_state  <= (w_a_beats == 4'd1) ? ACK : WRITE;
                  end else begin
                     r_denied <= 1'b1;
                     r_state  <= ACK;
                  end
               end
            end
            READ: begin
               if (w_rd_issue) r_beat <= r_beat + 4'd1;
               if (w_d_fire) begin
                  r_dbeat <= r_dbeat + 4'd1;
                  if (r_dbeat == r_beats - 4'd1) r_state <= IDLE;
               end
            end
            WRITE: begin
               if (w_a_fire) begin
                  r_beat <= r_beat + 4'd1;
                  if (r_beat == r_beats - 4'd1) r_state <= ACK;
               end
            end
            ACK: begin
               if (w_d_fire) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign tl_bus_d_valid           = (r_state == READ && w_fifo_vld) || (r_state == ACK);
   assign tl_bus_d_payload_opcode  = (r_state == READ) ? ACCESS_ACK_DATA : ACCESS_ACK;
   assign tl_bus_d_payload_param   = 3'd0;
   assign tl_bus_d_payload_size    = r_size;
   assign tl_bus_d_payload_source  = r_source;
   assign tl_bus_d_payload_denied  = (r_state == READ) ? w_fifo_pop_dat[64] :
                                     (r_state == ACK)  ? r_denied : 1'b0;
   assign tl_bus_d_payload_data    = (r_state == READ) ? w_fifo_pop_dat[63:0] : 64'd0;
   assign tl_bus_d_payload_corrupt = 1'b0;

   assign w_unused = ^{tl_bus_a_payload_param, tl_bus_a_payload_address[2:0], w_fifo_push_rdy};

endmodule

// File: tb/tb_tl_sram_responder.sv
// Directed bench for tl_sram_responder: a table of single-beat transactions plus
// hand-written burst, backpressure, denial and mid-burst reset sequences.
module tb_tl_sram_responder;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        a_valid;
   logic        a_ready;
   logic [2:0]  a_opcode;
   logic [2:0]  a_param;
   logic [2:0]  a_size;
   logic [1:0]  a_source;
   logic [31:0] a_address;
   logic [7:0]  a_mask;
   logic [63:0] a_data;
   logic        d_valid;
   logic        d_ready;
   logic [2:0]  d_opcode;
   logic [2:0]  d_param;
   logic [2:0]  d_size;
   logic [1:0]  d_source;
   logic        d_denied;
   logic [63:0] d_data;
   logic        d_corrupt;

   int n_vec = 0;
   int n_err = 0;

   logic [63:0] cap_data [16];
   logic [2:0]  cap_op   [16];
   logic [2:0]  cap_size [16];
   logic [1:0]  cap_src  [16];
   logic        cap_den  [16];
   int          cap_n;
   int          cap_cyc;
   int          stab_err;

   typedef struct {
      logic [2:0]  op;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [1:0]  src;
      logic [7:0]  mask;
      logic [63:0] wdata;
      logic [2:0]  exp_op;
      logic        exp_den;
      bit          chk_data;
      logic [63:0] exp_data;
   } vec_t;

   vec_t tbl [14];

   always #5 clk = ~clk;

   tl_sram_responder #(
      .ADDRESS_WIDTH (32),
      .MEM_WORDS     (4096),
      .SOURCE_WIDTH  (2)
   ) dut (
      .clk                      (clk),
      .reset_n                  (reset_n),
      .tl_bus_a_valid           (a_valid),
      .tl_bus_a_ready           (a_ready),
      .tl_bus_a_payload_opcode  (a_opcode),
      .tl_bus_a_payload_param   (a_param),
      .tl_bus_a_payload_size    (a_size),
      .tl_bus_a_payload_source  (a_source),
      .tl_bus_a_payload_address (a_address),
      .tl_bus_a_payload_mask    (a_mask),
      .tl_bus_a_payload_data    (a_data),
      .tl_bus_d_valid           (d_valid),
      .tl_bus_d_ready           (d_ready),
      .tl_bus_d_payload_opcode  (d_opcode),
      .tl_bus_d_payload_param   (d_param),
      .tl_bus_d_payload_size    (d_size),
      .tl_bus_d_payload_source  (d_source),
      .tl_bus_d_payload_denied  (d_denied),
      .tl_bus_d_payload_data    (d_data),
      .tl_bus_d_payload_corrupt (d_corrupt)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   // Called and returns on a falling edge; the handshake happens on the rising edge between.
   task automatic a_send(input logic [2:0] op, input logic [2:0] size, input logic [31:0] addr,
                         input logic [1:0] src, input logic [7:0] mask, input logic [63:0] data);
      int t = 0;
      a_valid   = 1'b1;
      a_opcode  = op;
      a_size    = size;
      a_address = addr;
      a_source  = src;
      a_mask    = mask;
      a_data    = data;
      while (!a_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!a_ready) chk("a_ready_timeout", 64'(a_ready), 64'd1);
      @(negedge clk);
      a_valid = 1'b0;
   endtask

   // Collects nbeats D beats; alt=1 drives d_ready 1,0,1,0,... and checks stalled payload stability.
   task automatic d_collect(input int nbeats, input bit alt);
      int          cyc = 0;
      bit          ph = 1'b1;
      bit          prev_stall = 1'b0;
      logic [63:0] prev_data = '0;
      cap_n    = 0;
      stab_err = 0;
      while (cap_n < nbeats && cyc < 200) begin
         if (prev_stall && (!d_valid || d_data !== prev_data)) stab_err++;
         d_ready = alt ? ph : 1'b1;
         ph      = ~ph;
         if (d_valid && d_ready) begin
            cap_data[cap_n] = d_data;
            cap_op[cap_n]   = d_opcode;
            cap_size[cap_n] = d_size;
            cap_src[cap_n]  = d_source;
            cap_den[cap_n]  = d_denied;
            cap_n++;
         end
         prev_stall = d_valid && !d_ready;
         prev_data  = d_data;
         @(negedge clk);
         cyc++;
      end
      d_ready = 1'b0;
      cap_cyc = cyc;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // {op, size, addr, src, mask, wdata, exp_op, exp_den, chk_data, exp_data}
      tbl[0]  = '{3'd4, 3'd3, 32'h48,   2'd1, 8'hFF, 64'h0,    3'd1, 1'b0, 1'b1, 64'h109};
      tbl[1]  = '{3'd4, 3'd2, 32'h7C,   2'd3, 8'hFF, 64'h0,    3'd1, 1'b0, 1'b1, 64'h10F};
      tbl[2]  = '{3'd0, 3'd3, 32'h0,    2'd0, 8'hFF, 64'h1234, 3'd0, 1'b0, 1'b0, 64'h0};
      tbl[3]  = '{3'd0, 3'd3, 32'h88,   2'd1, 8'hFF, 64'h0,    3'd0, 1'b0, 1'b0, 64'h0};
      tbl[4]  = '{3'd1, 3'd3, 32'h88,   2'd2, 8'h0F, '1,       3'd0, 1'b0, 1'b0, 64'h0};
      tbl[5]  = '{3'd4, 3'd3, 32'h88,   2'd0, 8'hFF, 64'h0,    3'd1, 1'b0, 1'b1, 64'h00000000FFFFFFFF};
      tbl[6]  = '{3'd1, 3'd3, 32'h88,   2'd3, 8'h80, 64'h5A00000000000000, 3'd0, 1'b0, 1'b0, 64'h0};
      tbl[7]  = '{3'd4, 3'd3, 32'h88,   2'd1, 8'hFF, 64'h0,    3'd1, 1'b0, 1'b1, 64'h5A000000FFFFFFFF};
      tbl[8]  = '{3'd2, 3'd3, 32'h88,   2'd2, 8'hFF, 64'h0,    3'd0, 1'b1, 1'b0, 64'h0};
      tbl[9]  = '{3'd4, 3'd3, 32'h8000, 2'd3, 8'hFF, 64'h0,    3'd1, 1'b1, 1'b1, 64'h0};
      tbl[10] = '{3'd0, 3'd3, 32'h8000, 2'd0, 8'hFF, 64'hDEAD, 3'd0, 1'b1, 1'b0, 64'h0};
      tbl[11] = '{3'd4, 3'd7, 32'h40,   2'd1, 8'hFF, 64'h0,    3'd1, 1'b1, 1'b1, 64'h0};
      tbl[12] = '{3'd4, 3'd3, 32'h0,    2'd2, 8'hFF, 64'h0,    3'd1, 1'b0, 1'b1, 64'h1234};
      tbl[13] = '{3'd4, 3'd3, 32'h88,   2'd0, 8'hFF, 64'h0,    3'd1, 1'b0, 1'b1, 64'h5A000000FFFFFFFF};

      reset_n = 1'b0; a_valid = 1'b0; a_opcode = '0; a_param = '0; a_size = '0;
      a_source = '0; a_address = '0; a_mask = '0; a_data = '0; d_ready = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst.a_ready", 64'(a_ready), 64'd0);
      chk("rst.d_valid", 64'(d_valid), 64'd0);
      chk("rst.denied", 64'(d_denied), 64'd0);
      reset_n = 1'b1;
      #1 chk("rel.a_ready_before_edge", 64'(a_ready), 64'd0);
      @(negedge clk);
      chk("rel.a_ready_after_edge", 64'(a_ready), 64'd1);

      // Preload words 8..15 with 0x100+i through a PutFull burst.
      for (int i = 0; i < 8; i++) begin
         a_send(3'd0, 3'd6, 32'h40, 2'd0, 8'hFF, 64'h108 + 64'(i));
         if (i < 7) chk($sformatf("pre.no_ack_beat%0d", i), 64'(d_valid), 64'd0);
      end
      d_collect(1, 1'b0);
      chk("pre.ack_n", 64'(cap_n), 64'd1);
      chk("pre.ack_op", 64'(cap_op[0]), 64'd0);
      chk("pre.ack_den", 64'(cap_den[0]), 64'd0);
      chk("pre.ack_size", 64'(cap_size[0]), 64'd6);

      // Get burst: latency 2 from the handshake, then back-to-back beats.
      a_send(3'd4, 3'd6, 32'h40, 2'd2, 8'h00, 64'h0);
      chk("get.a_ready_busy", 64'(a_ready), 64'd0);
      chk("get.vld_hs+0", 64'(d_valid), 64'd0);
      @(negedge clk);
      chk("get.vld_hs+1", 64'(d_valid), 64'd0);
      @(negedge clk);
      chk("get.vld_hs+2", 64'(d_valid), 64'd1);
      d_collect(8, 1'b0);
      chk("get.beats", 64'(cap_n), 64'd8);
      chk("get.cycles", 64'(cap_cyc), 64'd8);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("get.data%0d", i), cap_data[i], 64'h108 + 64'(i));
         chk($sformatf("get.op%0d", i), 64'(cap_op[i]), 64'd1);
      end
      chk("get.size", 64'(cap_size[7]), 64'd6);
      chk("get.src", 64'(cap_src[7]), 64'd2);
      chk("get.idle_after", 64'(a_ready), 64'd1);

      // Single-beat table.
      for (int i = 0; i < 14; i++) begin
         a_send(tbl[i].op, tbl[i].size, tbl[i].addr, tbl[i].src, tbl[i].mask, tbl[i].wdata);
         d_collect(1, 1'b0);
         chk($sformatf("tbl%0d.n", i), 64'(cap_n), 64'd1);
         chk($sformatf("tbl%0d.op", i), 64'(cap_op[0]), 64'(tbl[i].exp_op));
         chk($sformatf("tbl%0d.den", i), 64'(cap_den[0]), 64'(tbl[i].exp_den));
         chk($sformatf("tbl%0d.size", i), 64'(cap_size[0]), 64'(tbl[i].size));
         chk($sformatf("tbl%0d.src", i), 64'(cap_src[0]), 64'(tbl[i].src));
         if (tbl[i].chk_data) chk($sformatf("tbl%0d.data", i), cap_data[0], tbl[i].exp_data);
         chk($sformatf("tbl%0d.param", i), 64'(d_param), 64'd0);
         chk($sformatf("tbl%0d.corrupt", i), 64'(d_corrupt), 64'd0);
      end

      // PutFull burst at 0x80, ack only after the eighth beat, then readback.
      for (int i = 0; i < 8; i++) begin
         a_send(3'd0, 3'd6, 32'h80, 2'd3, 8'hFF, 64'hA0 + 64'(i));
         if (i == 0) chk("put.a_ready_write", 64'(a_ready), 64'd1);
         if (i == 6) chk("put.no_ack_beat7", 64'(d_valid), 64'd0);
      end
      chk("put.ack_vld", 64'(d_valid), 64'd1);
      chk("put.a_ready_ack", 64'(a_ready), 64'd0);
      d_collect(1, 1'b0);
      chk("put.ack_op", 64'(cap_op[0]), 64'd0);
      chk("put.ack_src", 64'(cap_src[0]), 64'd3);
      chk("put.ack_size", 64'(cap_size[0]), 64'd6);
      a_send(3'd4, 3'd6, 32'h80, 2'd0, 8'h00, 64'h0);
      d_collect(8, 1'b0);
      chk("rb.beats", 64'(cap_n), 64'd8);
      for (int i = 0; i < 8; i++) chk($sformatf("rb.data%0d", i), cap_data[i], 64'hA0 + 64'(i));

      // Get with d_ready toggling.
      a_send(3'd4, 3'd6, 32'h40, 2'd1, 8'h00, 64'h0);
      d_collect(8, 1'b1);
      chk("alt.beats", 64'(cap_n), 64'd8);
      for (int i = 0; i < 8; i++) chk($sformatf("alt.data%0d", i), cap_data[i], 64'h108 + 64'(i));
      chk("alt.stable", 64'(stab_err), 64'd0);
      chk("alt.no_extra", 64'(d_valid), 64'd0);
      @(negedge clk);
      chk("alt.no_extra2", 64'(d_valid), 64'd0);

      // Reset while beat 3 of a Get is on D.
      a_send(3'd4, 3'd6, 32'h40, 2'd2, 8'h00, 64'h0);
      d_collect(3, 1'b0);
      chk("mid.beat3_vld", 64'(d_valid), 64'd1);
      chk("mid.beat3_data", d_data, 64'h10B);
      reset_n = 1'b0;
      #1;
      chk("mid.rst_d_valid", 64'(d_valid), 64'd0);
      chk("mid.rst_a_ready", 64'(a_ready), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1 chk("mid.rel_a_ready_before", 64'(a_ready), 64'd0);
      @(negedge clk);
      chk("mid.rel_a_ready_after", 64'(a_ready), 64'd1);
      chk("mid.rel_d_valid", 64'(d_valid), 64'd0);
      a_send(3'd4, 3'd3, 32'h50, 2'd1, 8'h00, 64'h0);
      d_collect(1, 1'b0);
      chk("mid.new_n", 64'(cap_n), 64'd1);
      chk("mid.new_data", cap_data[0], 64'h10A);
      chk("mid.new_src", 64'(cap_src[0]), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
